// File: rtl/encoder_16x4_pkg.sv
// ---------------------------------------------------------------------------
// encoder_16x4_pkg
// Shared constants for the registered 16-to-4 priority encoder.
//   IN_W    : width of the request vector
//   IDX_W   : width of the encoded index
//   RST_OUT : value the index register takes in reset
//   RST_EO  : value the empty flag takes in reset (reads as "no request")
// ---------------------------------------------------------------------------
package encoder_16x4_pkg;

    localparam int              IN_W    = 16;
    localparam int              IDX_W   = 4;
    localparam logic [IDX_W-1:0] RST_OUT = 4'd0;
    localparam logic            RST_EO  = 1'b1;

endpackage : encoder_16x4_pkg

// File: rtl/encoder_16x4_priority_enc8.sv
// ---------------------------------------------------------------------------
// priority_enc8
// Combinational 8-to-3 priority encoder; the highest-numbered set bit wins.
// Ports:
//   req_i [7:0] : request byte
//   idx_o [2:0] : index of the highest set bit (0 when nothing is set)
//   any_o       : OR of all request bits
// ---------------------------------------------------------------------------
module priority_enc8 (
    input  logic [7:0] req_i,
    output logic [2:0] idx_o,
    output logic       any_o
);

    // Walking upwards lets every later (higher) set bit overwrite the
    // earlier one, so the last write is the highest-priority request.
    always_comb begin
        idx_o = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (req_i[i]) begin
                idx_o = 3'(i);
            end
        end
    end

    assign any_o = |req_i;

endmodule : priority_enc8

// File: rtl/encoder_16x4.sv
// ---------------------------------------------------------------------------
// encoder_16x4
// Registered 16-to-4 priority encoder. Reports the index of the highest set
// bit of the request vector one clock later, and flags the all-zero case.
// Ports:
//   in    [15:0] : request vector; bit i requests index i
//   out   [3:0]  : registered index of the highest set bit (valid when eo=0)
//   eo           : registered empty flag, 1 when the sampled vector was zero
//   clk          : rising-edge clock
//   rst_n        : synchronous active-low reset
// ---------------------------------------------------------------------------
module encoder_16x4
    import encoder_16x4_pkg::*;
(
    input  logic [IN_W-1:0]  in,
    output logic [IDX_W-1:0] out,
    output logic             eo,
    input  logic             clk,
    input  logic             rst_n
);

    logic [2:0]       idxHi;
    logic [2:0]       idxLo;
    logic             anyHi;
    logic             anyLo;
    logic [IDX_W-1:0] out_d;
    logic             eo_d;
    logic [IDX_W-1:0] out_q;
    logic             eo_q;

    priority_enc8 u_encHi (
        .req_i (in[15:8]),
        .idx_o (idxHi),
        .any_o (anyHi)
    );

    priority_enc8 u_encLo (
        .req_i (in[7:0]),
        .idx_o (idxLo),
        .any_o (anyLo)
    );

    // Any request in the high byte outranks the whole low byte, so the high
    // byte's presence becomes the MSB and selects which byte's index is used.
    // With no request at all the low encoder yields 0, giving out = 0.
    always_comb begin
        out_d = {anyHi, (anyHi ? idxHi : idxLo)};
        eo_d  = ~(anyHi | anyLo);
    end

    // Output stage; reset wins over a fresh encode on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= RST_OUT;
            eo_q  <= RST_EO;
        end else begin
            out_q <= out_d;
            eo_q  <= eo_d;
        end
    end

    assign out = out_q;
    assign eo  = eo_q;

endmodule : encoder_16x4

// File: tb/tb_encoder_16x4.sv
// ---------------------------------------------------------------------------
// tb_encoder_16x4
// Self-checking bench for encoder_16x4: directed reset / one-hot / priority /
// latency steps followed by random vectors, each compared to a reference
// model that finds the highest set bit arithmetically.
// ---------------------------------------------------------------------------
module tb_encoder_16x4;

    logic [15:0] in;
    logic [3:0]  out;
    logic        eo;
    logic        clk;
    logic        rst_n;

    int assertCount = 0;
    int failCount   = 0;

    logic [3:0] expOut;
    logic       expEo;

    encoder_16x4 dut (
        .in    (in),
        .out   (out),
        .eo    (eo),
        .clk   (clk),
        .rst_n (rst_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: for a nonzero vector the winning index is floor(log2(x)),
    // which equals clog2(x+1)-1. Reset or an empty vector gives 0 / empty.
    function automatic void refModel(input logic [15:0] x, input logic rst,
                                     output logic [3:0] o, output logic e);
        int v;
        v = int'(x);
        if (!rst || v == 0) begin
            o = 4'd0;
            e = 1'b1;
        end else begin
            o = 4'($clog2(v + 1) - 1);
            e = 1'b0;
        end
    endfunction

    // Drive a vector and reset level, let one rising edge take it, then
    // settle 1 time unit past the edge before anything is sampled.
    task automatic applyStimulus(input logic [15:0] vec, input logic rstLevel);
        in    = vec;
        rst_n = rstLevel;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] wantOut,
                               input logic wantEo);
        assertCount++;
        assert (out === wantOut)
        else begin
            failCount++;
            $error("[TB] FAIL %s out: observed=%0d expected=%0d", tag, out, wantOut);
        end
        assertCount++;
        assert (eo === wantEo)
        else begin
            failCount++;
            $error("[TB] FAIL %s eo: observed=%0b expected=%0b", tag, eo, wantEo);
        end
    endtask

    task automatic stepAndCheck(input string tag, input logic [15:0] vec,
                                input logic rstLevel);
        applyStimulus(vec, rstLevel);
        refModel(vec, rstLevel, expOut, expEo);
        checkOutput(tag, expOut, expEo);
    endtask

    initial begin
        logic [15:0] vec;
        logic        rst;

        // Reset held for two edges with every request asserted.
        applyStimulus(16'hFFFF, 1'b0);
        checkOutput("reset_edge1", 4'd0, 1'b1);
        applyStimulus(16'hFFFF, 1'b0);
        checkOutput("reset_edge2", 4'd0, 1'b1);

        // One-hot sweep; each bit's own position must come back.
        for (int i = 0; i < 16; i++) begin
            vec = 16'h0001 << i;
            applyStimulus(vec, 1'b1);
            checkOutput($sformatf("onehot_%0d", i), 4'(i), 1'b0);
        end

        applyStimulus(16'h0000, 1'b1);
        checkOutput("empty", 4'd0, 1'b1);

        applyStimulus(16'h8001, 1'b1);
        checkOutput("prio_8001", 4'd15, 1'b0);
        applyStimulus(16'h00F0, 1'b1);
        checkOutput("prio_00F0", 4'd7, 1'b0);
        applyStimulus(16'h0300, 1'b1);
        checkOutput("prio_0300", 4'd9, 1'b0);

        // Mid-stream reset pulse discards the result, next edge recovers.
        applyStimulus(16'h0400, 1'b0);
        checkOutput("midreset_low", 4'd0, 1'b1);
        applyStimulus(16'h0400, 1'b1);
        checkOutput("midreset_recover", 4'd10, 1'b0);

        // Back-to-back vectors each appear exactly one edge later.
        applyStimulus(16'h0002, 1'b1);
        checkOutput("latency_a", 4'd1, 1'b0);
        applyStimulus(16'h4000, 1'b1);
        checkOutput("latency_b", 4'd14, 1'b0);

        // Random vectors of varying density, with occasional reset pulses.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0:       vec = 16'($urandom);
                1:       vec = 16'($urandom & $urandom & $urandom);
                2:       vec = 16'h0001 << $urandom_range(0, 15);
                default: vec = ($urandom_range(0, 3) == 0) ? 16'h0000
                                                           : 16'($urandom >> 20);
            endcase
            rst = ($urandom_range(0, 15) != 0);
            stepAndCheck($sformatf("rand_%0d_%04h_r%0b", n, vec, rst), vec, rst);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule : tb_encoder_16x4
